// File: rtl/box_overlay_compositor.sv
`default_nettype none
// ============================================================================
// Module      : box_overlay_compositor
// Description : Two-stage pipelined overlay of up to NUM_BOXES rectangular
//               hit/hurt box borders on the sprite pixel stream. Box geometry,
//               enables, colours and game_state are shadowed at frame_start so
//               a frame is always drawn from one consistent snapshot.
//               Optional macro BOX_FILL_EN adds the box_fill port and a
//               checkerboard interior fill for filled boxes.
// Revision    : 1.0 - initial release
// ============================================================================
module box_overlay_compositor #(
    parameter int                 NUM_BOXES         = 6,
    parameter int                 COORD_W           = 10,
    parameter int                 COLOR_W           = 8,
    parameter logic [2:0]         DEBUG_STATE       = 3'd2,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 8'hE3,
    parameter logic [COLOR_W-1:0] BACKGROUND_COLOR  = 8'h7B,
    parameter int                 BLINK_SHIFT       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           pixel_valid,
    input  logic [COORD_W-1:0]             pixel_x,
    input  logic [COORD_W-1:0]             pixel_y,
    input  logic [COLOR_W-1:0]             pixel_data,
    input  logic [2:0]                     game_state,
    input  logic [NUM_BOXES-1:0]           box_en,
    input  logic [NUM_BOXES-1:0]           box_blink,
`ifdef BOX_FILL_EN
    input  logic [NUM_BOXES-1:0]           box_fill,
`endif
    input  logic [NUM_BOXES*COORD_W-1:0]   box_x1,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_x2,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_y1,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_y2,
    input  logic [NUM_BOXES*COLOR_W-1:0]   box_color,
    output logic [COLOR_W-1:0]             color_out,
    output logic                           out_valid
);

    localparam int c_CNT_W = BLINK_SHIFT + 1;

    // Shadow (per-frame snapshot) registers
    logic [NUM_BOXES-1:0]         sh_en_q,    sh_en_d;
    logic [NUM_BOXES-1:0]         sh_blink_q, sh_blink_d;
    logic [NUM_BOXES*COORD_W-1:0] sh_x1_q,    sh_x1_d;
    logic [NUM_BOXES*COORD_W-1:0] sh_x2_q,    sh_x2_d;
    logic [NUM_BOXES*COORD_W-1:0] sh_y1_q,    sh_y1_d;
    logic [NUM_BOXES*COORD_W-1:0] sh_y2_q,    sh_y2_d;
    logic [NUM_BOXES*COLOR_W-1:0] sh_color_q, sh_color_d;
    logic [2:0]                   sh_state_q, sh_state_d;
    logic [c_CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
`ifdef BOX_FILL_EN
    logic [NUM_BOXES-1:0]         sh_fill_q,  sh_fill_d;
`endif

    // Stage 1 registers
    logic [NUM_BOXES-1:0]         s1_hit_q,   s1_hit_d;
    logic [COLOR_W-1:0]           s1_data_q,  s1_data_d;
    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_dbg_q,   s1_dbg_d;
`ifdef BOX_FILL_EN
    logic [NUM_BOXES-1:0]         s1_fill_q,  s1_fill_d;
`endif

    // Stage 2 (output) registers
    logic [COLOR_W-1:0]           color_out_q, color_out_d;
    logic                         out_valid_q, out_valid_d;

    // Combinational per-box results
    logic [NUM_BOXES-1:0]         w_hit;
    logic                         w_blink_phase;
`ifdef BOX_FILL_EN
    logic [NUM_BOXES-1:0]         w_fill;
    logic                         w_checker;
    assign w_checker = pixel_x[0] ^ pixel_y[0];
`endif

    assign w_blink_phase = frame_cnt_q[BLINK_SHIFT];

    // Shadow next-state: snapshot all box inputs on frame_start, count frames
    always_comb begin
        sh_en_d     = sh_en_q;
        sh_blink_d  = sh_blink_q;
        sh_x1_d     = sh_x1_q;
        sh_x2_d     = sh_x2_q;
        sh_y1_d     = sh_y1_q;
        sh_y2_d     = sh_y2_q;
        sh_color_d  = sh_color_q;
        sh_state_d  = sh_state_q;
        frame_cnt_d = frame_cnt_q;
`ifdef BOX_FILL_EN
        sh_fill_d   = sh_fill_q;
`endif
        if (frame_start) begin
            sh_en_d     = box_en;
            sh_blink_d  = box_blink;
            sh_x1_d     = box_x1;
            sh_x2_d     = box_x2;
            sh_y1_d     = box_y1;
            sh_y2_d     = box_y2;
            sh_color_d  = box_color;
            sh_state_d  = game_state;
            frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef BOX_FILL_EN
            sh_fill_d   = box_fill;
`endif
        end
    end

    // Per-box border (and optional interior) hit detection against shadows
    generate
        for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
            logic [COORD_W-1:0] w_x1, w_x2, w_y1, w_y2;
            logic               w_ordered, w_in_x, w_in_y, w_vert, w_horz, w_active;
            assign w_x1      = sh_x1_q[i*COORD_W +: COORD_W];
            assign w_x2      = sh_x2_q[i*COORD_W +: COORD_W];
            assign w_y1      = sh_y1_q[i*COORD_W +: COORD_W];
            assign w_y2      = sh_y2_q[i*COORD_W +: COORD_W];
            // An inverted rectangle must not draw its lone x1/y1 edge
            assign w_ordered = (w_x1 <= w_x2) && (w_y1 <= w_y2);
            assign w_in_x    = (pixel_x >= w_x1) && (pixel_x <= w_x2);
            assign w_in_y    = (pixel_y >= w_y1) && (pixel_y <= w_y2);
            assign w_vert    = ((pixel_x == w_x1) || (pixel_x == w_x2)) && w_in_y;
            assign w_horz    = ((pixel_y == w_y1) || (pixel_y == w_y2)) && w_in_x;
            assign w_active  = sh_en_q[i] & ~(sh_blink_q[i] & w_blink_phase);
            assign w_hit[i]  = w_active & w_ordered & (w_vert | w_horz);
`ifdef BOX_FILL_EN
            assign w_fill[i] = w_active & sh_fill_q[i] & w_checker &
                               (pixel_x > w_x1) && (pixel_x < w_x2) &&
                               (pixel_y > w_y1) && (pixel_y < w_y2);
`endif
        end
    endgenerate

    // Stage 1 next-state: capture hit vector, pixel and debug-mode snapshot
    always_comb begin
        s1_hit_d   = w_hit;
        s1_data_d  = pixel_data;
        s1_valid_d = pixel_valid;
        s1_dbg_d   = (sh_state_q == DEBUG_STATE);
`ifdef BOX_FILL_EN
        s1_fill_d  = w_fill;
`endif
    end

    // Stage 2 next-state: priority select of box colour over sprite/background
    always_comb begin
        logic [COLOR_W-1:0] sprite;
        logic [COLOR_W-1:0] sel;
        sprite      = (s1_data_q == TRANSPARENT_COLOR) ? BACKGROUND_COLOR : s1_data_q;
        sel         = sprite;
`ifdef BOX_FILL_EN
        // Fills first so that any border hit below overrides them
        for (int k = NUM_BOXES - 1; k >= 0; k--) begin
            if (s1_fill_q[k]) sel = sh_color_q[k*COLOR_W +: COLOR_W];
        end
`endif
        // Descending scan leaves the lowest-index hit as the winner
        for (int k = NUM_BOXES - 1; k >= 0; k--) begin
            if (s1_hit_q[k]) sel = sh_color_q[k*COLOR_W +: COLOR_W];
        end
        color_out_d = color_out_q;
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            color_out_d = s1_dbg_q ? sel : sprite;
        end
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_en_q     <= '0;
            sh_blink_q  <= '0;
            sh_x1_q     <= '0;
            sh_x2_q     <= '0;
            sh_y1_q     <= '0;
            sh_y2_q     <= '0;
            sh_color_q  <= '0;
            sh_state_q  <= '0;
            frame_cnt_q <= '0;
            s1_hit_q    <= '0;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_dbg_q    <= 1'b0;
            color_out_q <= '0;
            out_valid_q <= 1'b0;
`ifdef BOX_FILL_EN
            sh_fill_q   <= '0;
            s1_fill_q   <= '0;
`endif
        end else begin
            sh_en_q     <= sh_en_d;
            sh_blink_q  <= sh_blink_d;
            sh_x1_q     <= sh_x1_d;
            sh_x2_q     <= sh_x2_d;
            sh_y1_q     <= sh_y1_d;
            sh_y2_q     <= sh_y2_d;
            sh_color_q  <= sh_color_d;
            sh_state_q  <= sh_state_d;
            frame_cnt_q <= frame_cnt_d;
            s1_hit_q    <= s1_hit_d;
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            s1_dbg_q    <= s1_dbg_d;
            color_out_q <= color_out_d;
            out_valid_q <= out_valid_d;
`ifdef BOX_FILL_EN
            sh_fill_q   <= sh_fill_d;
            s1_fill_q   <= s1_fill_d;
`endif
        end
    end

    assign color_out = color_out_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_box_overlay_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_box_overlay_compositor
// Description : Scoreboard bench for box_overlay_compositor. Directed pixels
//               push hand-derived colours into a queue; a monitor pops and
//               compares whenever out_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_box_overlay_compositor;

    localparam int NB = 6;
    localparam int CW = 10;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            pixel_valid = 1'b0;
    logic [CW-1:0]   pixel_x = '0;
    logic [CW-1:0]   pixel_y = '0;
    logic [KW-1:0]   pixel_data = '0;
    logic [2:0]      game_state = 3'd0;
    logic [NB-1:0]   box_en = '0;
    logic [NB-1:0]   box_blink = '0;
    logic [NB-1:0]   box_fill = '0;
    logic [NB*CW-1:0] box_x1, box_x2, box_y1, box_y2;
    logic [NB*KW-1:0] box_color;
    logic [KW-1:0]   color_out;
    logic            out_valid;

    logic [CW-1:0]   tx1 [NB];
    logic [CW-1:0]   tx2 [NB];
    logic [CW-1:0]   ty1 [NB];
    logic [CW-1:0]   ty2 [NB];
    logic [KW-1:0]   tcol[NB];

    logic [KW-1:0]   exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              pix_id = 0;
    logic [3:0]      fcnt = 4'd0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            box_x1[i*CW +: CW]    = tx1[i];
            box_x2[i*CW +: CW]    = tx2[i];
            box_y1[i*CW +: CW]    = ty1[i];
            box_y2[i*CW +: CW]    = ty2[i];
            box_color[i*KW +: KW] = tcol[i];
        end
    end

    box_overlay_compositor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_data  (pixel_data),
        .game_state  (game_state),
        .box_en      (box_en),
        .box_blink   (box_blink),
`ifdef BOX_FILL_EN
        .box_fill    (box_fill),
`endif
        .box_x1      (box_x1),
        .box_x2      (box_x2),
        .box_y1      (box_y1),
        .box_y2      (box_y2),
        .box_color   (box_color),
        .color_out   (color_out),
        .out_valid   (out_valid)
    );

    // Monitor: every valid output is checked against the oldest expectation
    always @(posedge clk) begin
        logic [KW-1:0] e;
        #1;
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: color_out=%h out_valid=1, expected no output", color_out);
            end else begin
                e = exp_q.pop_front();
                if (color_out !== e) begin
                    n_err++;
                    $display("FAIL pixel_%0d: color_out=%h, expected %h", pix_id, color_out, e);
                end
                pix_id++;
            end
        end
    end

    task automatic set_box(input int i, input int x1, input int x2, input int y1, input int y2,
                           input logic [KW-1:0] c, input logic en, input logic bl);
        tx1[i] = CW'(x1); tx2[i] = CW'(x2); ty1[i] = CW'(y1); ty2[i] = CW'(y2);
        tcol[i] = c; box_en[i] = en; box_blink[i] = bl;
    endtask

    task automatic pix(input int x, input int y, input logic [KW-1:0] d, input logic [KW-1:0] e);
        pixel_valid = 1'b1; pixel_x = CW'(x); pixel_y = CW'(y); pixel_data = d;
        exp_q.push_back(e);
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fcnt = fcnt + 4'd1;
    endtask

    // Pixel issued in the same cycle as frame_start
    task automatic pix_fs(input int x, input int y, input logic [KW-1:0] d, input logic [KW-1:0] e);
        frame_start = 1'b1;
        pix(x, y, d, e);
        frame_start = 1'b0;
        fcnt = fcnt + 4'd1;
    endtask

    task automatic check(input string name, input logic [KW-1:0] got, input logic [KW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NB; i++) set_box(i, 0, 0, 0, 0, 8'h00, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_color_out", color_out, 8'h00);
        check("reset_out_valid", {7'd0, out_valid}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Sprite path with overlays off
        pix(3, 4, 8'hE3, 8'h7B);
        pix(3, 5, 8'h1C, 8'h1C);

        // Single box, debug mode
        set_box(0, 10, 20, 10, 20, 8'hE0, 1'b1, 1'b0);
        game_state = 3'd2;
        fs();
        pix(10, 15, 8'h55, 8'hE0);
        pix(15, 15, 8'h55, 8'h55);
        pix(21, 15, 8'h55, 8'h55);
        pix(15, 15, 8'hE3, 8'h7B);
        pix(15, 20, 8'h55, 8'hE0);

        // Shared edge: priority, then lower box disabled
        set_box(1, 5, 10, 10, 20, 8'hFC, 1'b1, 1'b0);
        fs();
        pix(10, 12, 8'h55, 8'hE0);
        box_en[0] = 1'b0;
        fs();
        pix(10, 12, 8'h55, 8'hFC);
        pix(5, 20, 8'h55, 8'hFC);

        // Geometry changes take effect only at frame_start
        box_en[0] = 1'b1; box_en[1] = 1'b0;
        fs();
        set_box(0, 40, 50, 40, 50, 8'hE0, 1'b1, 1'b0);
        pix(10, 15, 8'h55, 8'hE0);
        pix(40, 45, 8'h55, 8'h55);
        pix_fs(10, 15, 8'h55, 8'hE0);
        pix(10, 15, 8'h55, 8'h55);
        pix(40, 45, 8'h55, 8'hE0);

        // Inverted box never draws
        set_box(0, 30, 20, 10, 20, 8'hE0, 1'b1, 1'b0);
        fs();
        pix(30, 15, 8'h55, 8'h55);
        pix(20, 15, 8'h55, 8'h55);
        pix(25, 10, 8'h55, 8'h55);

        // Single-pixel box and box at maximum coordinates
        set_box(0, 100, 100, 200, 200, 8'hE0, 1'b1, 1'b0);
        set_box(1, 1000, 1023, 1000, 1023, 8'hFC, 1'b1, 1'b0);
        fs();
        pix(100, 200, 8'h55, 8'hE0);
        pix(100, 201, 8'h55, 8'h55);
        pix(101, 200, 8'h55, 8'h55);
        pix(1023, 1010, 8'h55, 8'hFC);
        pix(1010, 1023, 8'h55, 8'hFC);
        pix(1022, 1022, 8'h55, 8'h55);

        // Non-debug game_state suppresses overlays
        game_state = 3'd0;
        fs();
        pix(100, 200, 8'h55, 8'h55);
        pix(100, 200, 8'hE3, 8'h7B);
        game_state = 3'd2;

        // Blink across a full counter wrap
        set_box(0, 10, 20, 10, 20, 8'hE0, 1'b1, 1'b1);
        box_en[1] = 1'b0;
        for (int f = 0; f < 18; f++) begin
            fs();
            pix(10, 15, 8'h55, fcnt[3] ? 8'h55 : 8'hE0);
        end

        // Reset mid-stream flushes an in-flight pixel and clears shadows
        repeat (3) @(negedge clk);
        pixel_valid = 1'b1; pixel_x = 10; pixel_y = 15; pixel_data = 8'h55;
        @(negedge clk);
        pixel_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_flush_valid", {7'd0, out_valid}, 8'h00);
        fcnt = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid_1", {7'd0, out_valid}, 8'h00);
        @(negedge clk);
        check("post_reset_valid_2", {7'd0, out_valid}, 8'h00);
        pix(10, 15, 8'h55, 8'h55);
        fs();
        pix(10, 15, 8'h55, 8'hE0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
